// File: rtl/reflex_pkg.sv
// Shared NinjaReflex types and constants: FSM state encoding, LFSR seed/taps,
// default timing windows and the registered status bundle.
package reflex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_GO    = 3'd2,
    ST_CLEAR = 3'd3,
    ST_LOSE  = 3'd4,
    ST_WON   = 3'd5
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 expressed as a mask over state bits [7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int unsigned DEF_BASE_WAIT = 500;
  localparam int unsigned DEF_WAIT_STEP = 100;
  localparam int unsigned DEF_WIN_L1    = 400;
  localparam int unsigned DEF_WIN_L2    = 250;
  localparam int unsigned DEF_WIN_L3    = 150;
  localparam int unsigned DEF_CNT_W     = 16;

  localparam int unsigned NUM_LEVELS = 3;
  localparam int unsigned LEVEL_W    = 2;

  typedef struct packed {
    logic       target;
    logic [2:0] lights;
    logic       fail;
    logic       win;
    logic       busy;
  } status_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; exposes the low OUT_W bits of its state.
module lfsr8
  import reflex_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] value_o
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  always_comb begin
    state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign value_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/reflex_level_ctrl.sv
// NinjaReflex round sequencer: random wait, stimulus, reaction window and
// three-level progression with cumulative level-cleared flags.
module reflex_level_ctrl
  import reflex_pkg::*;
#(
  parameter int unsigned BASE_WAIT = DEF_BASE_WAIT,
  parameter int unsigned WAIT_STEP = DEF_WAIT_STEP,
  parameter int unsigned WIN_L1    = DEF_WIN_L1,
  parameter int unsigned WIN_L2    = DEF_WIN_L2,
  parameter int unsigned WIN_L3    = DEF_WIN_L3,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic start,
  input  logic hit,
  output logic target,
  output logic light1,
  output logic light2,
  output logic light3,
  output logic fail,
  output logic win,
  output logic busy
);

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         lights_q, lights_d;
  status_t            out_q, out_d;

  logic [3:0]         rnd;
  logic [CNT_W-1:0]   wait_load;
  logic [CNT_W-1:0]   win_load;
  logic               cnt_expire;

  lfsr8 #(
    .OUT_W (4)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .value_o (rnd)
  );

  // A computed load of zero still costs one tick so the counter cannot wrap.
  function automatic logic [CNT_W-1:0] clamp_load(input logic [31:0] v);
    if (v == 32'd0) begin
      return CNT_W'(1);
    end
    return CNT_W'(v);
  endfunction

  always_comb begin
    wait_load = clamp_load(32'(BASE_WAIT) + 32'(rnd) * 32'(WAIT_STEP));
    case (level_q)
      2'd0:    win_load = clamp_load(32'(WIN_L1));
      2'd1:    win_load = clamp_load(32'(WIN_L2));
      default: win_load = clamp_load(32'(WIN_L3));
    endcase
    cnt_expire = (cnt_q <= CNT_W'(1));
  end

  // Next-state, level, counter and light-flag logic.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    lights_d = lights_q;
    case (state_q)
      ST_IDLE, ST_LOSE, ST_WON: begin
        if (start) begin
          state_d  = ST_WAIT;
          level_d  = '0;
          lights_d = '0;
          cnt_d    = wait_load;
        end
      end
      ST_WAIT: begin
        if (hit) begin
          state_d = ST_LOSE;
        end else if (tick) begin
          if (cnt_expire) begin
            state_d = ST_GO;
            cnt_d   = win_load;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_GO: begin
        if (hit) begin
          state_d = ST_CLEAR;
        end else if (tick) begin
          if (cnt_expire) begin
            state_d = ST_LOSE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_CLEAR: begin
        lights_d[level_q] = 1'b1;
        if (level_q == LEVEL_W'(NUM_LEVELS - 1)) begin
          state_d = ST_WON;
        end else begin
          state_d = ST_WAIT;
          level_d = level_q + LEVEL_W'(1);
          cnt_d   = wait_load;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        level_d  = '0;
        lights_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they are registered alongside it.
  always_comb begin
    out_d        = '0;
    out_d.target = (state_d == ST_GO);
    out_d.lights = (state_d == ST_WON) ? 3'b111 : lights_d;
    out_d.fail   = (state_d == ST_LOSE);
    out_d.win    = (state_d == ST_WON);
    out_d.busy   = (state_d == ST_WAIT) || (state_d == ST_GO) || (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      cnt_q    <= '0;
      lights_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      lights_q <= lights_d;
      out_q    <= out_d;
    end
  end

  assign target = out_q.target;
  assign light1 = out_q.lights[0];
  assign light2 = out_q.lights[1];
  assign light3 = out_q.lights[2];
  assign fail   = out_q.fail;
  assign win    = out_q.win;
  assign busy   = out_q.busy;

endmodule

// File: tb/tb_reflex_level_ctrl.sv
// Directed bench for reflex_level_ctrl: short-timing instance driven from a
// vector table plus hand sequences, and a default-timing instance for wait length.
module tb_reflex_level_ctrl;

  logic clk;
  logic rst, tick, start, hit;
  logic start2, hit2;
  logic target, light1, light2, light3, fail, win, busy;
  logic target2, light1b, light2b, light3b, fail2, win2, busy2;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] m_lfsr;

  reflex_level_ctrl #(
    .BASE_WAIT (4),
    .WAIT_STEP (0),
    .WIN_L1    (8),
    .WIN_L2    (6),
    .WIN_L3    (4),
    .CNT_W     (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .start  (start),
    .hit    (hit),
    .target (target),
    .light1 (light1),
    .light2 (light2),
    .light3 (light3),
    .fail   (fail),
    .win    (win),
    .busy   (busy)
  );

  reflex_level_ctrl dut2 (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .start  (start2),
    .hit    (hit2),
    .target (target2),
    .light1 (light1b),
    .light2 (light2b),
    .light3 (light3b),
    .fail   (fail2),
    .win    (win2),
    .busy   (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct {
    logic       start;
    logic       hit;
    logic       tick;
    logic       rst;
    logic [6:0] exp;   // {target, light1, light2, light3, fail, win, busy}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] outs1();
    return {target, light1, light2, light3, fail, win, busy};
  endfunction

  function automatic logic [6:0] outs2();
    return {target2, light1b, light2b, light3b, fail2, win2, busy2};
  endfunction

  task automatic add(input logic s, input logic h, input logic t, input logic r,
                     input logic [6:0] e);
    vec_t v;
    v.start = s; v.hit = h; v.tick = t; v.rst = r; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic s, input logic h, input logic t, input logic r);
    @(negedge clk);
    start = s; hit = h; tick = t; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (tgt l1 l2 l3 fail win busy)", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int n;
    int exp_len;
    rst = 1'b0; tick = 1'b0; start = 1'b0; hit = 1'b0;
    start2 = 1'b0; hit2 = 1'b0;

    // Reset, full three-level win with a start pulse while busy
    add(0,0,0,1, 7'b0000000);
    add(1,0,0,0, 7'b0000001);
    add(1,0,1,0, 7'b0000001);
    add(0,0,1,0, 7'b0000001);
    add(0,0,1,0, 7'b0000001);
    add(0,0,1,0, 7'b1000001);
    add(0,0,1,0, 7'b1000001);
    add(0,1,1,0, 7'b0000001);
    add(0,0,1,0, 7'b0100001);
    add(0,0,1,0, 7'b0100001);
    add(0,0,1,0, 7'b0100001);
    add(0,0,1,0, 7'b0100001);
    add(0,0,1,0, 7'b1100001);
    add(0,0,1,0, 7'b1100001);
    add(0,1,0,0, 7'b0100001);
    add(0,0,0,0, 7'b0110001);
    add(0,0,1,0, 7'b0110001);
    add(0,0,1,0, 7'b0110001);
    add(0,0,1,0, 7'b0110001);
    add(0,0,1,0, 7'b1110001);
    add(0,0,1,0, 7'b1110001);
    add(0,1,1,0, 7'b0110001);
    add(0,0,1,0, 7'b0111010);
    add(0,1,1,0, 7'b0111010);
    // False start in level-1 wait
    add(1,0,0,0, 7'b0000001);
    add(0,0,1,0, 7'b0000001);
    add(0,1,1,0, 7'b0000100);
    add(0,1,1,0, 7'b0000100);
    // Clear level 1, then time out in level 2 after six ticks of GO
    add(1,0,0,0, 7'b0000001);
    add(0,0,0,0, 7'b0000001);
    add(0,0,1,0, 7'b0000001);
    add(0,0,1,0, 7'b0000001);
    add(0,0,1,0, 7'b0000001);
    add(0,0,1,0, 7'b1000001);
    add(0,1,0,0, 7'b0000001);
    add(0,0,0,0, 7'b0100001);
    add(0,0,1,0, 7'b0100001);
    add(0,0,1,0, 7'b0100001);
    add(0,0,1,0, 7'b0100001);
    add(0,0,1,0, 7'b1100001);
    for (int i = 0; i < 5; i++) add(0,0,1,0, 7'b1100001);
    add(0,0,1,0, 7'b0100100);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].start, vecs[i].hit, vecs[i].tick, vecs[i].rst);
      chk($sformatf("vec%0d", i), outs1(), vecs[i].exp);
      if (i == 0) chk("dut2_reset", outs2(), 7'b0000000);
    end

    // hit and expiring tick on the same clk in GO: CLEAR wins
    step(1,0,0,0);
    for (int i = 0; i < 4; i++) step(0,0,1,0);
    chk("l1_go_entry", outs1(), 7'b1000001);
    for (int i = 0; i < 7; i++) step(0,0,1,0);
    chk("l1_go_cnt1", outs1(), 7'b1000001);
    step(0,1,1,0);
    chk("hit_tick_same", outs1(), 7'b0000001);
    step(0,0,0,0);
    chk("hit_tick_light", outs1(), 7'b0100001);

    // Reset during level-3 GO, then a fresh game restarts at level 1
    for (int i = 0; i < 4; i++) step(0,0,1,0);
    step(0,1,0,0);
    step(0,0,0,0);
    chk("l2_cleared", outs1(), 7'b0110001);
    for (int i = 0; i < 4; i++) step(0,0,1,0);
    chk("l3_go", outs1(), 7'b1110001);
    step(0,0,1,1);
    chk("rst_mid", outs1(), 7'b0000000);
    step(0,1,1,0);
    chk("idle_ignores", outs1(), 7'b0000000);
    step(1,0,0,0);
    chk("fresh_start", outs1(), 7'b0000001);
    for (int i = 0; i < 4; i++) step(0,0,1,0);
    chk("fresh_go", outs1(), 7'b1000001);
    step(0,1,0,0);
    step(0,0,0,0);
    chk("fresh_l1", outs1(), 7'b0100001);

    // Default timing: wait length follows the LFSR nibble at load
    @(negedge clk);
    start = 1'b0; hit = 1'b0; hit2 = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    chk("dut2_hit_idle", outs2(), 7'b0000000);
    @(negedge clk);
    hit2 = 1'b0; start2 = 1'b1;
    exp_len = 500 + int'(m_lfsr[3:0]) * 100;
    @(posedge clk); #1;
    chk("dut2_start", outs2(), 7'b0000001);
    n = 0;
    while (n < 2100) begin
      @(negedge clk);
      start2 = (n == 100);
      tick = 1'b1;
      @(posedge clk); #1;
      n++;
      if (target2) break;
    end
    chk_int("dut2_wait_len", n, exp_len);
    chk_int("dut2_wait_range", int'(n >= 500 && n <= 2000), 1);
    chk("dut2_go", outs2(), 7'b1000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reflex_level_ctrl.md
Name: reflex_level_ctrl

Overview:
- Sequences one NinjaReflex round: random wait, stimulus, reaction window, level advance.
- Produces the three level-cleared flags light1..light3 that drive the win LED display (1/2/3 LEDs lit).
- Sits between the debounced player button and tick generator on one side, and the LED/display blocks on the other.
- Three levels, each with a shorter reaction window. Any false start or timeout ends the game.

Parameters:
- BASE_WAIT, 500: minimum wait in ticks before the stimulus.
- WAIT_STEP, 100: ticks added per unit of random value. Wait = BASE_WAIT + lfsr[3:0]*WAIT_STEP.
- WIN_L1, 400: level-1 reaction window in ticks.
- WIN_L2, 250: level-2 reaction window in ticks.
- WIN_L3, 150: level-3 reaction window in ticks.
- CNT_W, 16: tick counter width. Every computed load value must be < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high; acts on the clk edge at which it is sampled 1.
- tick  in  1  1 kHz enable pulse, one clk wide.
- start  in  1  one-clk pulse. Starts or restarts the game.
- hit  in  1  one-clk debounced button pulse.
- target  out  1  stimulus LED. High only in GO.
- light1  out  1  level 1 cleared.
- light2  out  1  level 2 cleared.
- light3  out  1  level 3 cleared.
- fail  out  1  game lost. Held until next start.
- win  out  1  all three levels cleared. Held until next start.
- busy  out  1  high in WAIT, GO or CLEAR.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, level=0, counter=0, lfsr=8'hA5.
  - All outputs 0.
  - Reset mid-game aborts immediately, with no flag retained.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk.
  - Never all-zero.
  - Sampled only at wait-counter load.
- States: IDLE, WAIT, GO, CLEAR, LOSE, WON. All outputs are registered and decoded from state and flags.
- IDLE, LOSE, WON:
  - start=1 → WAIT, level=0, light1..3=0, fail=0, win=0, wait counter loaded.
  - hit and tick are ignored.
- WAIT:
  - hit=1 → LOSE (false start). Takes priority over tick.
  - Otherwise, on tick with counter==1 → GO, counter loaded with the current level's window.
  - Otherwise, on tick → counter decrements.
- GO:
  - target=1.
  - hit=1 → CLEAR. hit wins over a simultaneous expiring tick.
  - Otherwise, on tick with counter==1 → LOSE (timeout).
  - Otherwise, on tick → counter decrements.
- CLEAR (exactly one cycle):
  - Sets light[level].
  - level==2 → WON.
  - Otherwise level increments and the next state is WAIT, wait counter reloaded.
- LOSE: fail=1. Light flags keep the levels already cleared.
- WON: win=1, light1..3=1.
- start while busy is ignored.
- A hit pulse is consumed by exactly one transition.
- Latency:
  - hit sampled at edge N → state=CLEAR after N.
  - Light flag and next state become visible after edge N+1.
- Lights are cumulative: light2=1 implies light1=1.
- Counter arithmetic:
  - Unsigned, CNT_W bits.
  - A load value of 0 is treated as 1 (one tick minimum).
  - The counter never underflows.

Decomposition:
- Shared package reflex_pkg:
  - State enum constants (IDLE..WON, 3-bit encoding).
  - LFSR seed 8'hA5 and tap mask.
  - Default window constants, shared with the display and scoring blocks.
- One natural sub-module: lfsr8, an 8-bit free-running LFSR with synchronous reset. The FSM and counters stay in this block.

Test Plan:
1. Params BASE_WAIT=4, WAIT_STEP=0, WIN_L1/2/3=8/6/4. start, then hit 2 clk after each GO entry → target pulses 3 times; lights go 001→011→111; win=1; fail=0.
2. Same params. hit during WAIT of level 1 → LOSE next edge; fail=1; light1..3=0; target never asserted.
3. Clear level 1, then no hit in level 2 → after 6 ticks in GO, fail=1, light1=1, light2=0, target=0.
4. In GO with counter==1, assert hit and tick on the same clk → CLEAR, not LOSE; light[level] set on following edge.
5. rst=1 for one clk during GO of level 3 → all outputs 0 next edge; start then runs a fresh game from level 1.
6. start pulses while busy, and hit in IDLE/WON → no state change; outputs unchanged. Default params: wait length lies in 500..2000 ticks.
